// File: rtl/gantry_hall_pkg.sv
// Shared definitions for the gantry Hall decoder: register map, STATUS/CONTROL
// bit positions, Hall-to-sector table, FSM state encoding and default widths.
package gantry_hall_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FILT_W    = 8;
  localparam int unsigned PER_W_DEF = 24;

  // Register addresses (GANT_ADDR[2:0])
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_POSITION = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;

  // STATUS bit positions
  localparam int unsigned ST_CODE_LSB   = 0;
  localparam int unsigned ST_SECTOR_LSB = 3;
  localparam int unsigned ST_DIR        = 6;
  localparam int unsigned ST_FLAG_LSB   = 8;   // [8] INV, [9] SKIP, [10] STALL
  localparam int unsigned ST_STATE_LSB  = 12;

  // CONTROL bit positions
  localparam int unsigned CT_EN       = 0;
  localparam int unsigned CT_DIR_INV  = 1;
  localparam int unsigned CT_IRQ_LSB  = 2;     // [2] INV, [3] SKIP, [4] STALL
  localparam int unsigned CT_FILT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [FILT_W-1:0] filt_len;
    logic [2:0]        irq_en;    // {STALL, SKIP, INV}
    logic              dir_inv;
    logic              en;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } sector_t;

  // Commutation table; 000 and 111 are not legal Hall states.
  function automatic sector_t hall_to_sector(input logic [2:0] code);
    sector_t s;
    s = '{valid: 1'b1, sector: 3'd0};
    case (code)
      3'b101:  s.sector = 3'd0;
      3'b100:  s.sector = 3'd1;
      3'b110:  s.sector = 3'd2;
      3'b010:  s.sector = 3'd3;
      3'b011:  s.sector = 3'd4;
      3'b001:  s.sector = 3'd5;
      default: s.valid  = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gantry_hall_if.sv
// Register bus between a host (master) and the Hall decoder (slave).
//   GANT_ADDR     : register address, only [2:0] decoded
//   GANT_HALL_WE  : one-cycle write strobe
//   GANT_HALL_RE  : read enable
//   GANT_HALL_DI  : write data
//   GANT_HALL_DO  : read data (combinational from the slave)
interface gantry_hall_if;
  logic [31:0] GANT_ADDR;
  logic        GANT_HALL_WE;
  logic        GANT_HALL_RE;
  logic [31:0] GANT_HALL_DI;
  logic [31:0] GANT_HALL_DO;

  modport master (output GANT_ADDR, GANT_HALL_WE, GANT_HALL_RE, GANT_HALL_DI,
                  input  GANT_HALL_DO);
  modport slave  (input  GANT_ADDR, GANT_HALL_WE, GANT_HALL_RE, GANT_HALL_DI,
                  output GANT_HALL_DO);
endinterface

// File: rtl/gantry_hall_filter.sv
// Two-flop synchroniser plus persistence filter for the raw Hall code.
//   clk, rst_n  : clock, async active-low reset
//   i_hall      : raw {C,B,A} Hall inputs, asynchronous
//   i_filt_len  : clocks a new code must persist (0 treated as 1)
//   o_code      : filtered code
module gantry_hall_filter
  import gantry_hall_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        i_hall,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic [2:0]        o_code
);

  logic [2:0]        r_sync1, r_sync2, r_cand, r_filt;
  logic [FILT_W-1:0] r_cnt;
  logic [FILT_W-1:0] w_len;

  assign w_len = (i_filt_len == '0) ? FILT_W'(1) : i_filt_len;

  // r_cnt = consecutive clocks r_cand has been stable; accept once it reaches w_len
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_filt  <= '0;
    end else begin
      r_sync1 <= i_hall;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= FILT_W'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + FILT_W'(1);
      end
      if ((r_cnt >= w_len) && (r_cand != r_filt))
        r_filt <= r_cand;
    end
  end

  assign o_code = r_filt;

endmodule

// File: rtl/gantry_hall_decoder.sv
// Hall-sensor commutation decoder: tracks sector, signed position, direction
// and transition period, with sticky error flags and a level interrupt.
//   OPB_CLK, OPB_RST_N : clock, async active-low reset
//   GANT_HALL          : raw {C,B,A} Hall sensors
//   bus                : register bus (slave side)
//   GANT_HALL_IRQ      : registered level interrupt
module gantry_hall_decoder
  import gantry_hall_pkg::*;
#(
  parameter logic [FILT_W-1:0] FILT_RST = 8'h10,
  parameter int unsigned       PER_W    = PER_W_DEF
) (
  input  logic         OPB_CLK,
  input  logic         OPB_RST_N,
  input  logic [2:0]   GANT_HALL,
  gantry_hall_if.slave bus,
  output logic         GANT_HALL_IRQ
);

  fsm_state_t        r_state, w_state_nxt;
  ctrl_t             r_ctrl;
  logic [2:0]        r_sector;
  logic              r_dir;
  logic [31:0]       r_pos;
  logic [PER_W-1:0]  r_pcnt, r_period;
  logic [2:0]        r_flags;          // {STALL, SKIP, INV}
  logic              r_irq;

  logic [2:0]  w_code, w_addr, w_delta, w_flag_set, w_flag_clr;
  logic [3:0]  w_diff;
  sector_t     w_hs;
  logic        w_wr_status, w_wr_pos, w_wr_ctrl;
  logic        w_acq, w_track, w_load, w_move, w_fwd, w_bwd, w_step, w_up;
  logic [31:0] w_rdata;
  logic        w_unused;

  gantry_hall_filter u_filter (
    .clk        (OPB_CLK),
    .rst_n      (OPB_RST_N),
    .i_hall     (GANT_HALL),
    .i_filt_len (r_ctrl.filt_len),
    .o_code     (w_code)
  );

  assign w_unused    = ^bus.GANT_ADDR[31:3];
  assign w_addr      = bus.GANT_ADDR[2:0];
  assign w_wr_status = bus.GANT_HALL_WE && (w_addr == ADDR_STATUS);
  assign w_wr_pos    = bus.GANT_HALL_WE && (w_addr == ADDR_POSITION);
  assign w_wr_ctrl   = bus.GANT_HALL_WE && (w_addr == ADDR_CONTROL);

  // Sector step size modulo 6: 1 forward, 5 backward, anything else is a skip
  assign w_hs    = hall_to_sector(w_code);
  assign w_diff  = 4'(w_hs.sector) + 4'd6 - 4'(r_sector);
  assign w_delta = (w_diff >= 4'd6) ? 3'(w_diff - 4'd6) : 3'(w_diff);

  // EN low behaves as IDLE immediately, so nothing counts on the exit clock
  assign w_acq   = r_ctrl.en && (r_state == S_ACQUIRE);
  assign w_track = r_ctrl.en && (r_state == S_TRACK);
  assign w_load  = w_acq && w_hs.valid;
  assign w_move  = w_track && w_hs.valid && (w_hs.sector != r_sector);
  assign w_fwd   = w_move && (w_delta == 3'd1);
  assign w_bwd   = w_move && (w_delta == 3'd5);
  assign w_step  = w_fwd || w_bwd;
  assign w_up    = w_fwd ^ r_ctrl.dir_inv;

  assign w_flag_set = {w_track && (r_pcnt == '1),
                       w_move && !w_step,
                       (w_acq || w_track) && !w_hs.valid};
  assign w_flag_clr = w_wr_status ? bus.GANT_HALL_DI[ST_FLAG_LSB +: 3] : 3'b000;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (!r_ctrl.en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_ACQUIRE;
        S_ACQUIRE: if (w_hs.valid)  w_state_nxt = S_TRACK;
        S_TRACK:   if (!w_hs.valid) w_state_nxt = S_ACQUIRE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Position/period tracking, flags, control and interrupt
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_ctrl          <= '0;
      r_ctrl.filt_len <= FILT_RST;
      r_sector        <= '0;
      r_dir           <= 1'b0;
      r_pos           <= '0;
      r_pcnt          <= '0;
      r_period        <= '0;
      r_flags         <= '0;
      r_irq           <= 1'b0;
    end else begin
      if (w_load || w_move) r_sector <= w_hs.sector;
      if (w_step)           r_dir    <= w_up;

      // Host write beats a simultaneous count
      if (w_wr_pos)    r_pos <= bus.GANT_HALL_DI;
      else if (w_step) r_pos <= w_up ? r_pos + 32'd1 : r_pos - 32'd1;

      if (w_step) r_period <= r_pcnt;
      if (w_load)                      r_pcnt <= '0;
      else if (w_step)                 r_pcnt <= PER_W'(1);
      else if (w_track && r_pcnt != '1) r_pcnt <= r_pcnt + PER_W'(1);

      // Set beats a same-cycle W1C
      r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;

      if (w_wr_ctrl) begin
        r_ctrl.en       <= bus.GANT_HALL_DI[CT_EN];
        r_ctrl.dir_inv  <= bus.GANT_HALL_DI[CT_DIR_INV];
        r_ctrl.irq_en   <= bus.GANT_HALL_DI[CT_IRQ_LSB +: 3];
        r_ctrl.filt_len <= bus.GANT_HALL_DI[CT_FILT_LSB +: FILT_W];
      end

      r_irq <= |(r_flags & r_ctrl.irq_en);
    end
  end

  // Read mux
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_STATUS: begin
        w_rdata[ST_CODE_LSB   +: 3] = w_code;
        w_rdata[ST_SECTOR_LSB +: 3] = r_sector;
        w_rdata[ST_DIR]             = r_dir;
        w_rdata[ST_FLAG_LSB   +: 3] = r_flags;
        w_rdata[ST_STATE_LSB  +: 2] = r_state;
      end
      ADDR_POSITION: w_rdata = r_pos;
      ADDR_PERIOD:   w_rdata = 32'(r_period);
      ADDR_CONTROL: begin
        w_rdata[CT_EN]                  = r_ctrl.en;
        w_rdata[CT_DIR_INV]             = r_ctrl.dir_inv;
        w_rdata[CT_IRQ_LSB  +: 3]       = r_ctrl.irq_en;
        w_rdata[CT_FILT_LSB +: FILT_W]  = r_ctrl.filt_len;
      end
      default: w_rdata = '0;
    endcase
  end

  // Read data is forced to zero while in reset
  assign bus.GANT_HALL_DO = (bus.GANT_HALL_RE && OPB_RST_N) ? w_rdata : 32'h0;
  assign GANT_HALL_IRQ    = r_irq;

endmodule

// File: tb/tb_gantry_hall_decoder.sv
// Directed bench for gantry_hall_decoder: expectations are queued as each
// scenario is driven and popped as register reads / IRQ samples come back.
module tb_gantry_hall_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] hall, hall8;
  logic       irq, irq8;

  int n_pass   = 0;
  int n_checks = 0;

  string       q_tag[$];
  logic [31:0] q_exp[$];

  gantry_hall_if bus ();
  gantry_hall_if bus8 ();

  gantry_hall_decoder #(.FILT_RST(8'h10), .PER_W(24)) dut (
    .OPB_CLK       (clk),
    .OPB_RST_N     (rst_n),
    .GANT_HALL     (hall),
    .bus           (bus),
    .GANT_HALL_IRQ (irq)
  );

  gantry_hall_decoder #(.FILT_RST(8'h10), .PER_W(8)) dut8 (
    .OPB_CLK       (clk),
    .OPB_RST_N     (rst_n),
    .GANT_HALL     (hall8),
    .bus           (bus8),
    .GANT_HALL_IRQ (irq8)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_checks = n_checks + 1;
    if (q_exp.size() == 0) begin
      tag = "scoreboard_empty";
      exp = 32'hxxxxxxxx;
    end else begin
      tag = q_tag.pop_front();
      exp = q_exp.pop_front();
    end
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wr(input bit sel8, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel8) begin
      bus8.GANT_ADDR = 32'(a); bus8.GANT_HALL_DI = d; bus8.GANT_HALL_WE = 1'b1;
    end else begin
      bus.GANT_ADDR = 32'(a); bus.GANT_HALL_DI = d; bus.GANT_HALL_WE = 1'b1;
    end
    @(negedge clk);
    bus.GANT_HALL_WE  = 1'b0;
    bus8.GANT_HALL_WE = 1'b0;
  endtask

  task automatic rd(input bit sel8, input logic [2:0] a);
    logic [31:0] obs;
    @(negedge clk);
    if (sel8) begin
      bus8.GANT_ADDR = 32'(a); bus8.GANT_HALL_RE = 1'b1;
    end else begin
      bus.GANT_ADDR = 32'(a); bus.GANT_HALL_RE = 1'b1;
    end
    #1;
    obs = sel8 ? bus8.GANT_HALL_DO : bus.GANT_HALL_DO;
    bus.GANT_HALL_RE  = 1'b0;
    bus8.GANT_HALL_RE = 1'b0;
    sb_check(obs);
  endtask

  task automatic irq_chk(input bit sel8);
    @(negedge clk);
    #1;
    sb_check({31'b0, sel8 ? irq8 : irq});
  endtask

  task automatic hold(input bit sel8, input logic [2:0] code, input int n);
    if (sel8) hall8 = code;
    else      hall  = code;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    hall  = 3'b101;
    hall8 = 3'b101;
    bus.GANT_ADDR  = '0; bus.GANT_HALL_WE  = 1'b0; bus.GANT_HALL_RE  = 1'b0; bus.GANT_HALL_DI  = '0;
    bus8.GANT_ADDR = '0; bus8.GANT_HALL_WE = 1'b0; bus8.GANT_HALL_RE = 1'b0; bus8.GANT_HALL_DI = '0;
    repeat (3) @(negedge clk);

    // Read data gated during reset
    sb_push("rst_do_gated", 32'h0);
    rd(0, 3'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values (filter has not yet accepted the Hall code)
    sb_push("rst_status", 32'h0);
    sb_push("rst_position", 32'h0);
    sb_push("rst_period", 32'h0);
    sb_push("rst_control", 32'h0000_1000);
    sb_push("rst_irq", 32'h0);
    rd(0, 3'd0); rd(0, 3'd1); rd(0, 3'd2); rd(0, 3'd3); irq_chk(0);
    repeat (30) @(negedge clk);

    // Unmapped address reads zero and swallows writes
    wr(0, 3'd5, 32'hFFFF_FFFF);
    sb_push("unmapped_read", 32'h0);
    sb_push("control_after_unmapped", 32'h0000_1000);
    rd(0, 3'd5); rd(0, 3'd3);

    // Forward revolution, FILT_LEN=4
    wr(0, 3'd3, 32'h0000_0401);
    sb_push("fwd_position", 32'd6);
    sb_push("fwd_status", 32'h0000_2045);
    sb_push("fwd_period", 32'd1000);
    hold(0, 3'b101, 1000); hold(0, 3'b100, 1000); hold(0, 3'b110, 1000);
    hold(0, 3'b010, 1000); hold(0, 3'b011, 1000); hold(0, 3'b001, 1000);
    hold(0, 3'b101, 1000);
    rd(0, 3'd1); rd(0, 3'd0); rd(0, 3'd2);

    // Reverse revolution with DIR_INV counts up
    wr(0, 3'd1, 32'h0);
    wr(0, 3'd3, 32'h0000_0403);
    sb_push("rev_position", 32'd6);
    sb_push("rev_status", 32'h0000_2045);
    sb_push("rev_period", 32'd1000);
    hold(0, 3'b001, 1000); hold(0, 3'b011, 1000); hold(0, 3'b010, 1000);
    hold(0, 3'b110, 1000); hold(0, 3'b100, 1000); hold(0, 3'b101, 1000);
    rd(0, 3'd1); rd(0, 3'd0); rd(0, 3'd2);

    // 3-clock glitch rejected by a 4-clock filter
    wr(0, 3'd3, 32'h0000_0401);
    sb_push("glitch_position", 32'd6);
    sb_push("glitch_status", 32'h0000_2045);
    hold(0, 3'b100, 3); hold(0, 3'b101, 30);
    rd(0, 3'd1); rd(0, 3'd0);

    // Skip 101->110 with SKIP IRQ enabled, then W1C
    wr(0, 3'd3, 32'h0000_0409);
    sb_push("skip_status", 32'h0000_2256);
    sb_push("skip_position", 32'd6);
    sb_push("skip_irq", 32'd1);
    hold(0, 3'b110, 30);
    rd(0, 3'd0); rd(0, 3'd1); irq_chk(0);
    wr(0, 3'd0, 32'h0000_0200);
    sb_push("w1c_status", 32'h0000_2056);
    sb_push("w1c_irq", 32'd0);
    repeat (2) @(negedge clk);
    rd(0, 3'd0); irq_chk(0);

    // Invalid code in TRACK drops to ACQUIRE
    sb_push("inv_status", 32'h0000_1157);
    sb_push("inv_irq", 32'd0);
    hold(0, 3'b111, 30);
    rd(0, 3'd0); irq_chk(0);
    hold(0, 3'b110, 30);
    wr(0, 3'd0, 32'h0000_0100);
    sb_push("reacquire_status", 32'h0000_2056);
    rd(0, 3'd0);

    // Position wraps at the signed maximum
    wr(0, 3'd1, 32'h7FFF_FFFF);
    sb_push("wrap_position", 32'h8000_0000);
    sb_push("wrap_status", 32'h0000_205A);
    hold(0, 3'b010, 30);
    rd(0, 3'd1); rd(0, 3'd0);

    // 8-bit period counter saturates and raises STALL
    wr(1, 3'd3, 32'h0000_0411);
    sb_push("stall_status", 32'h0000_2405);
    sb_push("stall_irq", 32'd1);
    repeat (300) @(negedge clk);
    rd(1, 3'd0); irq_chk(1);
    sb_push("stall_period", 32'h0000_00FF);
    sb_push("stall_position", 32'd1);
    hold(1, 3'b100, 30);
    rd(1, 3'd2); rd(1, 3'd1);

    // EN=0 returns to IDLE, sticky flag kept
    wr(1, 3'd3, 32'h0);
    sb_push("en_off_status", 32'h0000_044C);
    sb_push("en_off_irq", 32'd0);
    repeat (3) @(negedge clk);
    rd(1, 3'd0); irq_chk(1);

    // Reset pulse in the middle of TRACK
    @(negedge clk);
    rst_n = 1'b0;
    sb_push("rst2_do_gated", 32'h0);
    rd(0, 3'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_push("rst2_status", 32'h0);
    sb_push("rst2_position", 32'h0);
    sb_push("rst2_period", 32'h0);
    sb_push("rst2_control", 32'h0000_1000);
    sb_push("rst2_irq", 32'h0);
    rd(0, 3'd0); rd(0, 3'd1); rd(0, 3'd2); rd(0, 3'd3); irq_chk(0);

    // Every queued expectation consumed
    n_checks = n_checks + 1;
    assert (q_exp.size() == 0) n_pass = n_pass + 1;
    else $error("FAIL scoreboard_leftover: observed %0d expected 0", q_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gantry_hall_decoder.md
GANTRY_HALL_DECODER -- requirements
Module: gantry_hall_decoder

Interface
REQ-001 SHALL have parameter FILT_RST, default 8'h10: reset value of CONTROL.FILT_LEN.
REQ-002 SHALL have parameter PER_W, default 24: width of the period counter.
REQ-003 SHALL have port OPB_CLK  in  1  32 MHz system clock; all logic is on this single clock.
REQ-004 SHALL have port OPB_RST_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port GANT_HALL  in  3  raw motor Hall sensors {C,B,A}, asynchronous to OPB_CLK.
REQ-006 SHALL have port GANT_ADDR  in  32  register address; only [2:0] decoded.
REQ-007 SHALL have port GANT_HALL_WE  in  1  one-cycle write strobe.
REQ-008 SHALL have port GANT_HALL_RE  in  1  read enable.
REQ-009 SHALL have port GANT_HALL_DI  in  32  write data.
REQ-010 SHALL have port GANT_HALL_DO  out  32  read data.
REQ-011 SHALL have port GANT_HALL_IRQ  out  1  level interrupt.

Function
REQ-012 SHALL synchronise GANT_HALL through 2 flops, then glitch-filter: filtered code takes the synced value only after it has been held constant for max(FILT_LEN,1) consecutive clocks.
REQ-013 SHALL map filtered code to sector: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5; 000 and 111 are invalid.
REQ-014 SHALL run FSM IDLE / ACQUIRE / TRACK; CONTROL.EN=0 forces IDLE from any state within 1 clock.
REQ-015 IDLE: ignore Hall changes; POSITION and PERIOD hold; EN=1 -> ACQUIRE.
REQ-016 ACQUIRE: valid filtered code -> load SECTOR, no count, -> TRACK; invalid code -> set INV_ERR, stay.
REQ-017 TRACK, filtered code changes to sector old+1 mod 6: POSITION +1, DIR=1 (with DIR_INV=1: POSITION -1, DIR=0).
REQ-018 TRACK, change to sector old-1 mod 6: POSITION -1, DIR=0 (inverted when DIR_INV=1).
REQ-019 TRACK, change to sector old+/-2 or +3: set SKIP_ERR, update SECTOR, POSITION unchanged.
REQ-020 TRACK, change to an invalid code: set INV_ERR, -> ACQUIRE.
REQ-021 SECTOR, POSITION and DIR SHALL update exactly 1 clock after the filtered code changes.
REQ-022 POSITION SHALL be 32-bit two's complement and wrap silently (0x7FFFFFFF+1 -> 0x80000000).
REQ-023 In TRACK, the period counter SHALL increment every clock.
REQ-024 On each valid +/-1 transition, the period counter value SHALL be copied to PERIOD and the counter cleared to 1.
REQ-025 The period counter SHALL saturate at all-ones and set STALL on reaching it.
REQ-026 Register map: 0 STATUS (RO except W1C): [2:0] filtered code, [5:3] SECTOR, [6] DIR, [8] INV_ERR, [9] SKIP_ERR, [10] STALL, [13:12] FSM state.
REQ-027 Register map: 1 POSITION (RW).
REQ-028 Register map: 2 PERIOD (RO, zero-extended).
REQ-029 Register map: 3 CONTROL (RW): [0] EN, [1] DIR_INV, [4:2] IRQ_EN for {STALL,SKIP,INV}, [15:8] FILT_LEN.
REQ-030 Addresses 4-7 SHALL read 0 and ignore writes.
REQ-031 GANT_HALL_DO SHALL be combinational mux of addressed register while RE=1, else 32'h0; no tristate.
REQ-032 Write of 1 to STATUS[10:8] SHALL clear the corresponding sticky flag.
REQ-033 If a flag set and its W1C clear occur in the same clock, the set SHALL win.
REQ-034 If a POSITION write and a count event occur in the same clock, the write SHALL win; the PERIOD capture still occurs.
REQ-035 GANT_HALL_IRQ SHALL equal OR of (sticky flag AND IRQ_EN), registered (1-clock latency).

Reset
REQ-036 On OPB_RST_N low, all state SHALL clear asynchronously: FSM=IDLE, POSITION=0, PERIOD=0, flags=0, CONTROL=0 except FILT_LEN=FILT_RST.
REQ-037 On OPB_RST_N low, sync and filter flops SHALL clear to 000, GANT_HALL_IRQ=0, GANT_HALL_DO=0.
REQ-038 Release SHALL take effect on the first OPB_CLK edge after deassertion; reset mid-TRACK discards all history.

Structure
REQ-039 Package gantry_hall_pkg SHALL hold register addresses, STATUS/CONTROL bit positions, hall-to-sector table, FSM state encoding and PER_W default.
REQ-040 Synchroniser plus glitch filter SHALL be sub-module gantry_hall_filter (inputs raw code, FILT_LEN; output filtered code).

Verification
REQ-041 Bench SHALL check: EN=1, FILT_LEN=4, drive 101,100,110,010,011,001,101 each 1000 clocks -> POSITION=6, DIR=1, PERIOD=1000, no flags.
REQ-042 Bench SHALL check: same sequence reversed with DIR_INV=1 -> POSITION=+6.
REQ-043 Bench SHALL check: 3-clock glitch 101->100->101 with FILT_LEN=4 -> POSITION unchanged, no flags.
REQ-044 Bench SHALL check: jump 101->110 -> SKIP_ERR=1, POSITION unchanged, IRQ=1 if IRQ_EN[1]; W1C 0x200 -> flag and IRQ clear.
REQ-045 Bench SHALL check: drive 111 in TRACK -> INV_ERR=1, state ACQUIRE.
REQ-046 Bench SHALL check: PER_W=8 with no transitions for 300 clocks -> STALL=1, counter held at 255.
REQ-047 Bench SHALL check: POSITION=0x7FFFFFFF plus one forward step -> 0x80000000.
REQ-048 Bench SHALL check: OPB_RST_N pulse mid-TRACK -> all registers at reset values, including FILT_LEN=0x10.
